// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two combinational reads, one synchronous write, r0 reads zero
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RFWr,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);
  localparam int N = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [N];
  logic [DATA_W-1:0] regs_d [N];
  logic              wr_en;
  logic              byp1;
  logic              byp2;
  assign wr_en = RFWr && (WA1 != '0);
  // next state keeps every register except the addressed one; r0 is never a target
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[WA1] = WD;
  end
  // storage, cleared asynchronously; reset also blocks writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end
  // write-through is gated by rst_n so reads stay zero throughout reset
  always_comb begin
    byp1 = BYPASS && rst_n && wr_en && (RA1 == WA1);
    byp2 = BYPASS && rst_n && wr_en && (RA2 == WA1);
    RD1  = (RA1 == '0) ? '0 : byp1 ? WD : regs_q[RA1];
    RD2  = (RA2 == '0) ? '0 : byp2 ? WD : regs_q[RA2];
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file, default (BYPASS=0) and write-through (BYPASS=1) instances
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RFWr = 1'b0;
  logic [4:0]  WA1 = '0, RA1 = '0, RA2 = '0;
  logic [31:0] WD = '0;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [31:0] mdl [32];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int checks = 0;
  int errors = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .RFWr(RFWr), .WA1(WA1), .RA1(RA1), .RA2(RA2),
    .WD(WD), .RD1(rd1_a), .RD2(rd2_a));
  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .RFWr(RFWr), .WA1(WA1), .RA1(RA1), .RA2(RA2),
    .WD(WD), .RD1(rd1_b), .RD2(rd2_b));

  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RFWr = 1'b1; WA1 = a; WD = d;
    @(posedge clk);
    #1;
    RFWr = 1'b0;
    if (rst_n && a != 5'd0) mdl[a] = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rst_n = 1'b0; RFWr = 1'b1; WA1 = 5'd5; WD = 32'hFFFF_FFFF; RA1 = 5'd5; RA2 = 5'd31;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin errors++; $display("FAIL reset_bypass_rd1 got %h exp %h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL reset_hold_rd1 got %h exp %h", rd1_a, e); end
    @(negedge clk);
    RFWr = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL reset_rd2 got %h exp %h", rd2_a, e); end
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'h1234_5678);
    do_write(5'd31, 32'hDEAD_BEEF);
    RA1 = 5'd3; RA2 = 5'd31;
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'hDEAD_BEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL basic_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL basic_rd2 got %h exp %h", rd2_a, e); end
  endtask

  task automatic test_reg0();
    do_write(5'd0, 32'hA5A5_A5A5);
    RA1 = 5'd0; RA2 = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL reg0_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL reg0_rd2 got %h exp %h", rd2_a, e); end
  endtask

  task automatic test_write_disable();
    do_write(5'd7, 32'h1111_1111);
    @(negedge clk);
    RFWr = 1'b0; WA1 = 5'd7; WD = 32'h2222_2222;
    @(posedge clk);
    #1;
    RA1 = 5'd7; RA2 = 5'd7;
    exp_q.push_back(32'h1111_1111); exp_q.push_back(32'h1111_1111);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL wen_off_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL wen_off_rd2_same_addr got %h exp %h", rd2_a, e); end
  endtask

  task automatic test_same_cycle();
    do_write(5'd9, 32'h1);
    @(negedge clk);
    RFWr = 1'b1; WA1 = 5'd9; WD = 32'h2; RA1 = 5'd9; RA2 = 5'd9;
    exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h2);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL same_cyc_nobyp_before got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin errors++; $display("FAIL same_cyc_byp_rd1 got %h exp %h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin errors++; $display("FAIL same_cyc_byp_rd2 got %h exp %h", rd2_b, e); end
    @(posedge clk);
    #1;
    mdl[9] = 32'h2;
    exp_q.push_back(32'h2);
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL same_cyc_nobyp_after got %h exp %h", rd1_a, e); end
    @(negedge clk);
    WA1 = 5'd0; WD = 32'hCAFE_F00D; RA1 = 5'd0; RA2 = 5'd3;
    exp_q.push_back(32'h0); exp_q.push_back(mdl[3]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin errors++; $display("FAIL byp_reg0_rd1 got %h exp %h", rd1_b, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin errors++; $display("FAIL byp_other_rd2 got %h exp %h", rd2_b, e); end
    @(posedge clk);
    #1;
    RFWr = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) do_write(5'($urandom_range(0, 31)), $urandom);
    for (int i = 0; i < 32; i++) begin
      RA1 = 5'(i); RA2 = 5'(31 - i);
      exp_q.push_back(mdl[i]); exp_q.push_back(mdl[31 - i]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1_a !== e) begin errors++; $display("FAIL b2b_rd1 addr %0d got %h exp %h", i, rd1_a, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_b !== e) begin errors++; $display("FAIL b2b_rd2 addr %0d got %h exp %h", 31 - i, rd2_b, e); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    RA1 = 5'd17; RA2 = 5'd30;
    exp_q.push_back(32'd17); exp_q.push_back(32'd30);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL fill_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL fill_rd2 got %h exp %h", rd2_a, e); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL async_clr_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin errors++; $display("FAIL async_clr_rd2 got %h exp %h", rd2_b, e); end
    for (int i = 1; i < 32; i += 6) begin
      RA1 = 5'(i); RA2 = 5'(i + 1);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1_a !== e) begin errors++; $display("FAIL async_all_rd1 addr %0d got %h exp %h", i, rd1_a, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_a !== e) begin errors++; $display("FAIL async_all_rd2 addr %0d got %h exp %h", i + 1, rd2_a, e); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd4, 32'h44);
    RA1 = 5'd4; RA2 = 5'd5;
    exp_q.push_back(32'h44); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL post_rst_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL post_rst_rd2 got %h exp %h", rd2_a, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reg0();
    test_write_disable();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
